vblank_update_arbiter: RTL and testbench

- Shares the vertical-blanking window of the XGA timing generator between up to N game-logic requesters, e.g. car position, track scroll and score update.
- Each requester may mutate frame-visible state only while holding a one-hot grant.
- Grants are issued round-robin, at most once per requester per blanking interval. Each grant is bounded by a cycle budget.
- Sits between the timing generator (consumes vblnk) and the game-state registers and memory write ports.

---
 rtl/vblank_update_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_vblank_update_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vblank_update_arbiter.sv
// vblank_update_arbiter
//
// Shares the vertical-blanking window between up to N game-logic requesters
// (car position, track scroll, score update, ...). A requester may touch
// frame-visible state only while it holds its bit of the one-hot grant.
// Grants are issued round-robin, at most once per requester per blanking
// interval, and each grant is bounded by MAX_GRANT_CYCLES.
//
// Ports:
//   pclk        in   pixel clock, the only clock
//   rst         in   synchronous active-low reset
//   vblnk       in   vertical blank from the timing generator (pclk domain)
//   req[N]      in   level request per requester, held until served
//   done[N]     in   completion; only honoured for the granted index
//   gnt[N]      out  one-hot grant, zero outside blanking
//   frame_tick  out  one-cycle pulse at the start of each blanking interval
//   overrun     out  one-cycle pulse when a grant is revoked (timeout/blank end)
//   busy        out  high while a grant is active
//
// Optional build macro VBLANK_ARB_STATS_EN adds:
//   overrun_cnt[8]   saturating count of overrun pulses
//   max_grant[TW]    largest timer value seen at any grant end
module vblank_update_arbiter #(
  parameter int N                = 4,
  parameter int MAX_GRANT_CYCLES = 4096,
  parameter int TW               = 16
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vblnk,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  gnt,
  output logic          frame_tick,
  output logic          overrun,
  output logic          busy
`ifdef VBLANK_ARB_STATS_EN
  ,
  output logic [7:0]    overrun_cnt,
  output logic [TW-1:0] max_grant
`endif
);

  localparam int            RW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_GRANT_CYCLES - 1);
  localparam logic [RW-1:0] IDX_LAST   = RW'(N - 1);
  localparam logic [N-1:0]  ONE        = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARB, GRANT, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic          vblnk_q_reg;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [RW-1:0] idx_reg, idx_next;
  logic [N-1:0]  served_reg, served_next;
  logic [RW-1:0] rr_reg, rr_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          busy_reg, busy_next;
  logic          frame_tick_reg, frame_tick_next;
  logic          overrun_reg, overrun_next;

  logic          vb_rise, vb_fall;
  logic [N-1:0]  pend;
  logic [N-1:0]  done_hit_vec;
  logic          done_hit;
  logic          timer_last;
  logic [RW-1:0] idx_inc;
  logic          sel_found;
  logic [RW-1:0] sel_idx;
  logic [RW-1:0] pos;

  assign vb_rise    = vblnk & ~vblnk_q_reg;
  assign vb_fall    = ~vblnk & vblnk_q_reg;
  assign pend       = req & ~served_reg;
  assign timer_last = (timer_reg == TIMER_LAST);
  assign idx_inc    = (idx_reg == IDX_LAST) ? '0 : idx_reg + RW'(1);

  // A done is only meaningful from the requester currently holding the grant;
  // stray completions from other indices are masked off here.
  for (genvar gi = 0; gi < N; gi++) begin : g_done_hit
    assign done_hit_vec[gi] = done[gi] & gnt_reg[gi];
  end
  assign done_hit = |done_hit_vec;

  // Round-robin pick: first pending index at or above rr, wrapping to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = RW'((int'(rr_reg) + k) % N);
      if (!sel_found && pend[pos]) begin
        sel_found = 1'b1;
        sel_idx   = pos;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    idx_next        = idx_reg;
    served_next     = served_reg;
    rr_next         = rr_reg;
    timer_next      = timer_reg;
    busy_next       = busy_reg;
    frame_tick_next = 1'b0;
    overrun_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (vb_rise) begin
          state_next      = ARB;
          frame_tick_next = 1'b1;
          served_next     = '0;
        end
      end
      ARB: begin
        if (!vblnk) begin
          state_next = IDLE;
        end else if (sel_found) begin
          gnt_next   = ONE << sel_idx;
          idx_next   = sel_idx;
          timer_next = '0;
          busy_next  = 1'b1;
          state_next = GRANT;
        end else begin
          state_next = DRAIN;
        end
      end
      GRANT: begin
        timer_next = timer_reg + TW'(1);
        if (done_hit || vb_fall || timer_last) begin
          gnt_next  = '0;
          busy_next = 1'b0;
          // A blank-end revoke leaves the requester unserved and rr untouched
          // so it is first in line next frame; a done always counts as served,
          // even when it coincides with the end of blanking.
          if (done_hit || !vb_fall) begin
            served_next[idx_reg] = 1'b1;
            rr_next              = idx_inc;
          end
          overrun_next = !done_hit;
          state_next   = vb_fall ? IDLE : ARB;
        end
      end
      DRAIN: begin
        if (!vblnk) begin
          state_next = IDLE;
        end else if (|pend) begin
          state_next = ARB;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      vblnk_q_reg    <= 1'b0;
      gnt_reg        <= '0;
      idx_reg        <= '0;
      served_reg     <= '0;
      rr_reg         <= '0;
      timer_reg      <= '0;
      busy_reg       <= 1'b0;
      frame_tick_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vblnk_q_reg    <= vblnk;
      gnt_reg        <= gnt_next;
      idx_reg        <= idx_next;
      served_reg     <= served_next;
      rr_reg         <= rr_next;
      timer_reg      <= timer_next;
      busy_reg       <= busy_next;
      frame_tick_reg <= frame_tick_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign gnt        = gnt_reg;
  assign frame_tick = frame_tick_reg;
  assign overrun    = overrun_reg;
  assign busy       = busy_reg;

`ifdef VBLANK_ARB_STATS_EN
  logic [7:0]    overrun_cnt_reg;
  logic [TW-1:0] max_grant_reg;
  logic          grant_end;

  assign grant_end = (state_reg == GRANT) && (gnt_next == '0);

  always_ff @(posedge pclk) begin
    if (!rst) begin
      overrun_cnt_reg <= '0;
      max_grant_reg   <= '0;
    end else begin
      if (overrun_next && (overrun_cnt_reg != 8'hFF)) begin
        overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
      end
      if (grant_end && (timer_reg > max_grant_reg)) begin
        max_grant_reg <= timer_reg;
      end
    end
  end

  assign overrun_cnt = overrun_cnt_reg;
  assign max_grant   = max_grant_reg;
`endif

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Self-checking bench for vblank_update_arbiter (N=4, 16-cycle grant budget).
// Expected grants are queued when a frame is set up and popped by a monitor
// each time a new grant appears.
module tb_vblank_update_arbiter;

  localparam int N    = 4;
  localparam int MAXG = 16;
  localparam int TW   = 16;

  logic         pclk = 1'b0;
  logic         rst = 1'b0;
  logic         vblnk = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] gnt;
  logic         frame_tick;
  logic         overrun;
  logic         busy;
`ifdef VBLANK_ARB_STATS_EN
  logic [7:0]    overrun_cnt;
  logic [TW-1:0] max_grant;
`endif

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];
  int ovr_obs = 0;
  int ft_obs = 0;
  int gap_log[8];

  always #5 pclk = ~pclk;

  vblank_update_arbiter #(
    .N(N),
    .MAX_GRANT_CYCLES(MAXG),
    .TW(TW)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .vblnk(vblnk),
    .req(req),
    .done(done),
    .gnt(gnt),
    .frame_tick(frame_tick),
    .overrun(overrun),
    .busy(busy)
`ifdef VBLANK_ARB_STATS_EN
    ,
    .overrun_cnt(overrun_cnt),
    .max_grant(max_grant)
`endif
  );

  // Grant monitor: one-hot / blanking invariant and scoreboard pop.
  logic [N-1:0] gnt_prev = '0;
  logic         vb_prev = 1'b0;
  logic [N-1:0] exp_g;
  always @(negedge pclk) begin
    if (gnt !== '0) begin
      checks++;
      if (!$onehot(gnt) || (!vblnk && !vb_prev)) begin
        errors++;
        $display("FAIL gnt_invariant: gnt=%b vblnk=%b, required one-hot inside blanking", gnt, vblnk);
      end
    end
    if (gnt !== '0 && gnt_prev === '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: gnt=%b, required no grant", gnt);
      end else begin
        exp_g = exp_q.pop_front();
        if (gnt !== exp_g) begin
          errors++;
          $display("FAIL grant_order: gnt=%b, required %b", gnt, exp_g);
        end else begin
          $display("grant %b at %0t", gnt, $time);
        end
      end
    end
    gnt_prev = gnt;
    vb_prev  = vblnk;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
    if (overrun === 1'b1) ovr_obs++;
    if (frame_tick === 1'b1) ft_obs++;
  endtask

  task automatic end_frame();
    vblnk = 1'b0;
    repeat (3) tick();
  endtask

  // Answers n grants in turn, each with done after 'hold' cycles; records
  // how many cycles each grant took to appear.
  task automatic serve(input int n, input int hold);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (gnt === '0 && w < 64) begin
        tick();
        w++;
      end
      gap_log[i] = w;
      repeat (hold - 1) tick();
      done = gnt;
      tick();
      done = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b required 0000", gnt); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b required 0", frame_tick); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
`ifdef VBLANK_ARB_STATS_EN
    checks++;
    if (overrun_cnt !== 8'd0 || max_grant !== '0) begin
      errors++;
      $display("FAIL reset_stats: got cnt=%0d max=%0d required 0/0", overrun_cnt, max_grant);
    end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    ovr_obs = 0;
    ft_obs  = 0;
    req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    vblnk = 1'b1;
    tick();
    checks++;
    if (frame_tick !== 1'b1 || gnt !== '0) begin
      errors++;
      $display("FAIL rr_frame_tick: frame_tick=%b gnt=%b required 1/0000", frame_tick, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rr_first_grant: gnt=%b busy=%b ft=%b required 0001/1/0", gnt, busy, frame_tick);
    end
    serve(4, 10);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (gap_log[i] != 1) begin
        errors++;
        $display("FAIL rr_gap: grant %0d came %0d cycles after drop, required 1", i, gap_log[i]);
      end
    end
    repeat (3) tick();
    checks++;
    if (gnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: gnt=%b busy=%b required 0000/0", gnt, busy);
    end
    end_frame();
    checks++;
    if (ft_obs != 1 || ovr_obs != 0) begin
      errors++;
      $display("FAIL rr_pulses: frame_tick=%0d overrun=%0d required 1/0", ft_obs, ovr_obs);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_missing: %0d grants outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_fairness();
    int n;
    for (int f = 0; f < 3; f++) begin
      ft_obs = 0;
      case (f)
        0: begin
          req = 4'b1111; n = 4;
          exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
          exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        end
        1: begin
          req = 4'b0100; n = 1;
          exp_q.push_back(4'b0100);
        end
        default: begin
          req = 4'b1111; n = 4;
          exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
          exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        end
      endcase
      vblnk = 1'b1;
      tick();
      serve(n, 5);
      repeat (4) tick();
      end_frame();
      checks++;
      if (exp_q.size() != 0 || ft_obs != 1) begin
        errors++;
        $display("FAIL fair_frame%0d: outstanding=%0d frame_ticks=%0d required 0/1", f, exp_q.size(), ft_obs);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (gap_log[i] != 1) begin
          errors++;
          $display("FAIL fair_gap: frame %0d grant %0d latency %0d required 1", f, i, gap_log[i]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    int cnt;
    ovr_obs = 0;
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    vblnk = 1'b1;
    tick();
    tick();
    cnt = 0;
    while (gnt !== '0 && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != MAXG) begin
      errors++;
      $display("FAIL timeout_len: gnt high %0d cycles required %0d", cnt, MAXG);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL timeout_overrun: overrun=%b at revoke required 1", overrun);
    end
    repeat (6) tick();
    checks++;
    if (ovr_obs != 1 || gnt !== '0) begin
      errors++;
      $display("FAIL timeout_after: overruns=%0d gnt=%b required 1/0000", ovr_obs, gnt);
    end
    end_frame();
    req = '0;
  endtask

  task automatic test_blank_end();
    ovr_obs = 0;
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    vblnk = 1'b1;
    tick();
    tick();
    repeat (3) tick();
    vblnk = 1'b0;
    tick();
    checks++;
    if (gnt !== '0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL blank_end_revoke: gnt=%b overrun=%b required 0000/1", gnt, overrun);
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL blank_end_pulse: overrun=%b required 0", overrun);
    end
    tick();
    // index 1 was not served, so it must lead the next frame
    req = 4'b0110;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    vblnk = 1'b1;
    tick();
    serve(2, 3);
    repeat (2) tick();
    end_frame();
    checks++;
    if (exp_q.size() != 0 || ovr_obs != 1) begin
      errors++;
      $display("FAIL blank_end_next: outstanding=%0d overruns=%0d required 0/1", exp_q.size(), ovr_obs);
    end
    req = '0;
  endtask

  task automatic test_simultaneous();
    ovr_obs = 0;
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    vblnk = 1'b1;
    tick();
    tick();
    done = 4'b1000;
    repeat (3) tick();
    checks++;
    if (gnt !== 4'b0001 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: gnt=%b overrun=%b required 0001/0", gnt, overrun);
    end
    done  = 4'b0001;
    vblnk = 1'b0;
    tick();
    done = '0;
    checks++;
    if (gnt !== '0 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_vs_fall: gnt=%b overrun=%b busy=%b required 0000/0/0", gnt, overrun, busy);
    end
    repeat (3) tick();
    checks++;
    if (ovr_obs != 0) begin
      errors++;
      $display("FAIL done_vs_fall_ovr: overruns=%0d required 0", ovr_obs);
    end
    exp_q.push_back(4'b0001);
    vblnk = 1'b1;
    tick();
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL done_vs_fall_idle: frame_tick=%b required 1", frame_tick);
    end
    serve(1, 4);
    end_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simult_missing: outstanding=%0d required 0", exp_q.size());
    end
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    vblnk = 1'b1;
    tick();
    tick();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || overrun !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b busy=%b ovr=%b ft=%b required all 0", gnt, busy, overrun, frame_tick);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_grant_seen: outstanding=%0d required 0", exp_q.size());
    end
    vblnk = 1'b0;
    req   = '0;
    rst   = 1'b1;
    repeat (2) tick();
  endtask

`ifdef VBLANK_ARB_STATS_EN
  task automatic test_stats();
    ovr_obs = 0;
    req = 4'b1111;
    for (int f = 0; f < 75; f++) begin
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      vblnk = 1'b1;
      repeat (80) tick();
      vblnk = 1'b0;
      repeat (2) tick();
      if (f == 2) begin
        checks++;
        if (overrun_cnt !== 8'd12) begin
          errors++;
          $display("FAIL stats_count: overrun_cnt=%0d required 12", overrun_cnt);
        end
      end
    end
    checks++;
    if (overrun_cnt !== 8'd255 || ovr_obs != 300) begin
      errors++;
      $display("FAIL stats_saturate: overrun_cnt=%0d pulses=%0d required 255/300", overrun_cnt, ovr_obs);
    end
    checks++;
    if (max_grant !== TW'(MAXG - 1)) begin
      errors++;
      $display("FAIL stats_max_grant: max_grant=%0d required %0d", max_grant, MAXG - 1);
    end
    req = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_blank_end();
    test_simultaneous();
    test_reset_mid_grant();
`ifdef VBLANK_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
